// File: rtl/apb_protocol_monitor.sv
// Passive APB4 protocol monitor: tracks the transfer phase, raises sticky per-rule flags,
// keeps saturating counters, captures the first violation and drives a maskable irq.
module apb_protocol_monitor #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_DEPTH      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter logic [6:0]  IRQ_MASK       = 7'h7F
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    clr,
  output logic [6:0]              err_flags,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic [CNT_WIDTH-1:0]    wr_count,
  output logic [CNT_WIDTH-1:0]    rd_count,
  output logic                    first_valid,
  output logic [2:0]              first_err_code,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic                    irq
);

  typedef enum logic [1:0] {StIdle, StSetup, StWait} phase_e;

  localparam int unsigned          StrbW    = DATA_WIDTH / 8;
  localparam int unsigned          WaitW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0]  DepthLim = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

  phase_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [StrbW-1:0]        strb_q, strb_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WaitW-1:0]        wait_q, wait_d;
  logic                    first_edge_q;
  logic [6:0]              flags_q, flags_d;
  logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
  logic                    fv_q, fv_d;
  logic [2:0]              code_q, code_d;
  logic [ADDR_WIDTH-1:0]   faddr_q, faddr_d;
  logic                    irq_q, irq_d;

  logic                    xfer_en, complete, wait_cyc, changed;
  logic [6:0]              viol;
  logic [2:0]              low_code;
  logic                    unused_prdata;

  assign unused_prdata = ^PRDATA;

  assign xfer_en  = PSEL & PENABLE;
  assign complete = xfer_en & PREADY;
  assign wait_cyc = xfer_en & ~PREADY;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CntMax) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Phase tracking, bus snapshot and wait-run counter
  always_comb begin
    state_d = StIdle;
    if (PSEL && !PENABLE) begin
      state_d = StSetup;
    end else if (wait_cyc) begin
      state_d = StWait;
    end
    addr_d  = addr_q;
    write_d = write_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    if (state_d != StIdle) begin
      addr_d  = PADDR;
      write_d = PWRITE;
      strb_d  = PSTRB;
      wdata_d = PWDATA;
    end
    wait_d = '0;
    if (wait_cyc) begin
      wait_d = (wait_q == WaitW'(TIMEOUT_CYCLES)) ? wait_q : wait_q + WaitW'(1);
    end
  end

  always_comb begin
    changed = (PADDR != addr_q) || (PWRITE != write_q) || (PSTRB != strb_q) ||
              (write_q && (PWDATA != wdata_q));
    viol    = '0;
    viol[0] = xfer_en && (state_q == StIdle) && !first_edge_q;
    viol[1] = (state_q == StSetup) && !xfer_en;
    viol[2] = (state_q == StWait) && (!xfer_en || changed) && !first_edge_q;
    viol[3] = PSLVERR && !complete;
    viol[4] = complete && ({1'b0, PADDR} >= DepthLim) && !PSLVERR;
    // Equality with TIMEOUT-1 before saturation makes this fire once per transfer
    viol[5] = wait_cyc && (wait_q == WaitW'(TIMEOUT_CYCLES - 1));
    viol[6] = PSEL && !PWRITE && (PSTRB != '0);
  end

  // Bookkeeping: clr zeroes first, then this cycle's events are applied on top
  always_comb begin
    flags_d   = clr ? '0 : flags_q;
    err_cnt_d = clr ? '0 : err_cnt_q;
    wr_cnt_d  = clr ? '0 : wr_cnt_q;
    rd_cnt_d  = clr ? '0 : rd_cnt_q;
    fv_d      = clr ? 1'b0 : fv_q;
    code_d    = clr ? '0 : code_q;
    faddr_d   = clr ? '0 : faddr_q;
    low_code  = '0;
    for (int i = 6; i >= 0; i--) begin
      if (viol[i]) low_code = 3'(i);
    end
    flags_d = flags_d | viol;
    if (|viol) err_cnt_d = sat_inc(err_cnt_d);
    if (complete && PWRITE) wr_cnt_d = sat_inc(wr_cnt_d);
    if (complete && !PWRITE) rd_cnt_d = sat_inc(rd_cnt_d);
    if (!fv_d && (|viol)) begin
      fv_d    = 1'b1;
      code_d  = low_code;
      faddr_d = PADDR;
    end
    irq_d = |(flags_q & IRQ_MASK);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      write_q      <= 1'b0;
      strb_q       <= '0;
      wdata_q      <= '0;
      wait_q       <= '0;
      first_edge_q <= 1'b1;
      flags_q      <= '0;
      err_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      fv_q         <= 1'b0;
      code_q       <= '0;
      faddr_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      strb_q       <= strb_d;
      wdata_q      <= wdata_d;
      wait_q       <= wait_d;
      first_edge_q <= 1'b0;
      flags_q      <= flags_d;
      err_cnt_q    <= err_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      fv_q         <= fv_d;
      code_q       <= code_d;
      faddr_q      <= faddr_d;
      irq_q        <= irq_d;
    end
  end

  assign err_flags      = flags_q;
  assign err_count      = err_cnt_q;
  assign wr_count       = wr_cnt_q;
  assign rd_count       = rd_cnt_q;
  assign first_valid    = fv_q;
  assign first_err_code = code_q;
  assign first_err_addr = faddr_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Bench for apb_protocol_monitor: directed bus scenarios plus random traffic, every cycle
// checked against a reference model phrased in terms of the previous sampled bus cycle.
module tb_apb_protocol_monitor;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned TMO     = 4;
  localparam int unsigned CW      = 4;
  localparam int          CMAX    = 15;
  localparam logic [6:0]  MASK    = 7'h7F;

  logic          pclk = 1'b0;
  logic          preset;
  logic          psel, penable, pwrite, pready, pslverr, clr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [3:0]    pstrb;
  logic [6:0]    err_flags;
  logic [CW-1:0] err_count, wr_count, rd_count;
  logic          first_valid;
  logic [2:0]    first_err_code;
  logic [AW-1:0] first_err_addr;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  apb_protocol_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW), .IRQ_MASK(MASK)
  ) u_dut (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PREADY(pready), .PSLVERR(pslverr), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata),
    .PSTRB(pstrb), .clr(clr), .err_flags(err_flags), .err_count(err_count),
    .wr_count(wr_count), .rd_count(rd_count), .first_valid(first_valid),
    .first_err_code(first_err_code), .first_err_addr(first_err_addr), .irq(irq)
  );

  always #5 pclk = ~pclk;

  // Reference model state: previous sampled cycle plus observable bookkeeping
  bit          m_first;
  bit          p_sel, p_en, p_rdy, p_wr;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_strb;
  int          m_run, m_flags, m_err, m_wr, m_rd, m_code;
  bit          m_fv, m_irq;
  logic [31:0] m_faddr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_first = 1; p_sel = 0; p_en = 0; p_rdy = 0; p_wr = 0;
    p_addr = '0; p_wdata = '0; p_strb = '0; m_run = 0;
    m_flags = 0; m_err = 0; m_wr = 0; m_rd = 0; m_code = 0; m_fv = 0; m_irq = 0;
    m_faddr = '0;
  endtask

  task automatic model_step();
    int  v;
    bit  en, done, prev_setup, prev_wait;
    v          = 0;
    en         = psel && penable;
    done       = en && pready;
    prev_setup = p_sel && !p_en;
    prev_wait  = p_sel && p_en && !p_rdy;
    if (en && !prev_setup && !prev_wait && !m_first) v |= 1;
    if (prev_setup && !en) v |= 2;
    if (prev_wait && !m_first && (!en || paddr != p_addr || pwrite != p_wr ||
        pstrb != p_strb || (p_wr && pwdata != p_wdata))) v |= 4;
    if (pslverr && !done) v |= 8;
    if (done && paddr >= DEPTH && !pslverr) v |= 16;
    if (en && !pready) begin
      m_run++;
      if (m_run == TMO) v |= 32;
    end else begin
      m_run = 0;
    end
    if (psel && !pwrite && pstrb != 0) v |= 64;
    m_irq = ((m_flags & int'(MASK)) != 0);
    if (clr) begin
      m_flags = 0; m_err = 0; m_wr = 0; m_rd = 0; m_fv = 0; m_code = 0; m_faddr = '0;
    end
    m_flags |= v;
    if (v != 0) m_err = sat(m_err + 1);
    if (done && pwrite) m_wr = sat(m_wr + 1);
    if (done && !pwrite) m_rd = sat(m_rd + 1);
    if (!m_fv && v != 0) begin
      m_fv = 1;
      m_faddr = paddr;
      for (int i = 6; i >= 0; i--) if (v[i]) m_code = i;
    end
    p_sel = psel; p_en = penable; p_rdy = pready; p_wr = pwrite;
    p_addr = paddr; p_wdata = pwdata; p_strb = pstrb;
    m_first = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge pclk);
    #1;
    check_eq("flags", err_flags, m_flags);
    check_eq("errcnt", err_count, m_err);
    check_eq("wrcnt", wr_count, m_wr);
    check_eq("rdcnt", rd_count, m_rd);
    check_eq("fvalid", first_valid, m_fv);
    check_eq("fcode", first_err_code, m_code);
    check_eq("faddr", first_err_addr, m_faddr);
    check_eq("irq", irq, m_irq);
  endtask

  task automatic drive(input bit s, input bit e, input bit w, input bit r, input bit er,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                       input bit c);
    psel = s; penable = e; pwrite = w; pready = r; pslverr = er;
    paddr = a; pwdata = d; pstrb = st; clr = c; prdata = $urandom;
    step();
  endtask

  task automatic idle(input bit c);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, c);
  endtask

  // chg_at: wait-cycle index (1-based) on which PWDATA switches to chg_d; 0 = never
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st, input int waits, input bit er,
                      input int chg_at, input logic [31:0] chg_d);
    logic [31:0] dd;
    dd = d;
    drive(1, 0, w, 0, 0, a, dd, st, 0);
    for (int i = 1; i <= waits; i++) begin
      if (i == chg_at) dd = chg_d;
      drive(1, 1, w, 0, 0, a, dd, st, 0);
    end
    drive(1, 1, w, 1, er, a, dd, st, 0);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset = 1;
    #1;
    check_eq("rst_flags", err_flags, 0);
    check_eq("rst_err", err_count, 0);
    check_eq("rst_wr", wr_count, 0);
    check_eq("rst_rd", rd_count, 0);
    check_eq("rst_fv", first_valid, 0);
    check_eq("rst_code", first_err_code, 0);
    check_eq("rst_addr", first_err_addr, 0);
    check_eq("rst_irq", irq, 0);
    model_reset();
    @(negedge pclk);
    preset = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 0;
    psel = 0; penable = 0; pwrite = 0; pready = 0; pslverr = 0;
    paddr = '0; pwdata = '0; prdata = '0; pstrb = '0; clr = 0;
    model_reset();
    #3;
    do_reset();

    // Clean write then read at 0x10
    xfer(1, 32'h10, 32'h1234_5678, 4'hF, 0, 0, 0, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0);
    idle(0);
    check_eq("tp1_wr", wr_count, 1);
    check_eq("tp1_rd", rd_count, 1);
    check_eq("tp1_flags", err_flags, 0);
    check_eq("tp1_irq", irq, 0);

    // PWDATA changes on the second of three wait cycles
    idle(1);
    xfer(1, 32'h20, 32'hA5, 4'hF, 3, 0, 2, 32'h5A);
    check_eq("tp2_flags", err_flags, 7'h04);
    check_eq("tp2_code", first_err_code, 2);
    check_eq("tp2_addr", first_err_addr, 32'h20);
    check_eq("tp2_irq", irq, 1);

    // Six wait states against a timeout of four
    idle(1);
    xfer(1, 32'h30, 32'hCAFE, 4'h3, 6, 0, 0, 0);
    idle(0);
    check_eq("tp3_flags", err_flags, 7'h20);
    check_eq("tp3_err", err_count, 1);
    check_eq("tp3_wr", wr_count, 1);

    // PENABLE without setup, PSLVERR outside completion
    idle(1);
    drive(1, 1, 0, 0, 1, 32'h10, 32'h0, 4'h0, 0);
    check_eq("tp4_flags", err_flags, 7'h09);
    check_eq("tp4_err", err_count, 1);
    check_eq("tp4_code", first_err_code, 0);
    drive(1, 1, 0, 1, 0, 32'h10, 32'h0, 4'h0, 0);
    check_eq("tp4_rd", rd_count, 1);

    // Out-of-range read, first OKAY then SLVERR
    idle(1);
    xfer(0, DEPTH, 32'h0, 4'h0, 0, 0, 0, 0);
    check_eq("tp5_flags", err_flags, 7'h10);
    xfer(0, DEPTH, 32'h0, 4'h0, 1, 1, 0, 0);
    check_eq("tp5_flags2", err_flags, 7'h10);
    check_eq("tp5_rd", rd_count, 2);
    check_eq("tp5_err", err_count, 1);

    // clr coincident with a read-strobe violation
    drive(1, 0, 0, 0, 0, 32'h40, 32'h0, 4'hF, 1);
    check_eq("tp6_flags", err_flags, 7'h40);
    check_eq("tp6_err", err_count, 1);
    check_eq("tp6_code", first_err_code, 6);
    drive(1, 1, 0, 1, 0, 32'h40, 32'h0, 4'hF, 0);

    // Reset mid-wait, then resume the in-flight access
    drive(1, 0, 1, 0, 0, 32'h50, 32'h77, 4'hF, 0);
    drive(1, 1, 1, 0, 0, 32'h50, 32'h77, 4'hF, 0);
    do_reset();
    drive(1, 1, 1, 1, 0, 32'h50, 32'h77, 4'hF, 0);
    check_eq("rs_flags", err_flags, 0);
    check_eq("rs_wr", wr_count, 1);
    idle(0);

    // Counter saturation
    idle(1);
    for (int i = 0; i < 17; i++) xfer(1, 32'h8, i, 4'h1, 0, 0, 0, 0);
    check_eq("sat_wr", wr_count, CMAX);

    // Random traffic: mostly legal transfers interleaved with arbitrary bus cycles
    for (int it = 0; it < 400; it++) begin
      if (it == 200) do_reset();
      if ($urandom_range(0, 9) < 5) begin
        bit          w;
        int          waits, chg;
        logic [3:0]  st;
        w     = 1'($urandom_range(0, 1));
        waits = $urandom_range(0, 5);
        chg   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
        st    = w ? 4'($urandom) : (($urandom_range(0, 7) == 0) ? 4'hF : 4'h0);
        xfer(w, $urandom_range(0, 511), $urandom, st, waits,
             1'($urandom_range(0, 3) == 0), chg, $urandom);
      end else begin
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 5) == 0), $urandom_range(0, 511), $urandom,
              4'($urandom), 1'($urandom_range(0, 19) == 0));
      end
    end
    idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_protocol_monitor.md
# apb_protocol_monitor

Synthesizable, parametrised APB4 protocol monitor that sits passively on the bus between any APB master and the APB slave under test. It tracks the transfer phase with a small state machine and checks phase sequencing, wait-state signal stability, PSLVERR qualification, address range, read-strobe legality and PREADY timeout. It records sticky per-rule error flags, saturating transfer and violation counters, and the first violation's code and address. It raises a maskable interrupt, and is usable in silicon debug as well as in simulation.

## Interface
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width (multiple of 8); PSTRB is DATA_WIDTH/8
- MEM_DEPTH, 256, legal address space; PADDR >= MEM_DEPTH is out of range
- TIMEOUT_CYCLES, 16, consecutive wait cycles (PREADY low in ACCESS) that constitute a timeout; >= 1
- CNT_WIDTH, 16, width of every counter
- IRQ_MASK, 7'h7F, per-flag interrupt enable
---
- PCLK  in  1  bus clock, all sampling on rising edge
- PRESET  in  1  asynchronous, active-high reset
- PSEL, PENABLE, PWRITE, PREADY, PSLVERR  in  1 each  APB bus signals (observed only)
- PADDR  in  ADDR_WIDTH  address
- PWDATA, PRDATA  in  DATA_WIDTH  data
- PSTRB  in  DATA_WIDTH/8  write strobes
- clr  in  1  synchronous clear of flags, counters and first-error capture
- err_flags  out  7  sticky violation flags, bit map below
- err_count  out  CNT_WIDTH  cycles with at least one violation, saturating
- wr_count, rd_count  out  CNT_WIDTH  completed writes/reads, saturating
- first_valid  out  1  first_err_code/first_err_addr hold a capture
- first_err_code  out  3  bit index of first violation
- first_err_addr  out  ADDR_WIDTH  PADDR sampled with first violation
- irq  out  1  |(err_flags & IRQ_MASK), registered

## Operation
- Phase FSM state reflects the previous sampled cycle: IDLE, SETUP (PSEL & !PENABLE), WAIT (PSEL & PENABLE & !PREADY). A completing cycle (PSEL & PENABLE & PREADY) returns state to IDLE.
- Transitions: any state with PSEL & !PENABLE goes to SETUP. PSEL & PENABLE & !PREADY goes to WAIT. Completion or !PSEL goes to IDLE.
- Flag bits, checked on each sampled cycle:
  - 0 ENABLE_NO_SETUP: PSEL & PENABLE while state IDLE.
  - 1 SETUP_NO_ACCESS: state SETUP and current cycle is not PSEL & PENABLE.
  - 2 UNSTABLE: state WAIT and current cycle has !PSEL, !PENABLE, or changed PADDR/PWRITE/PSTRB, or (write) changed PWDATA versus the held copy.
  - 3 ERR_NO_READY: PSLVERR high outside a completing cycle.
  - 4 ADDR_RANGE: completing cycle with PADDR >= MEM_DEPTH and PSLVERR low.
  - 5 TIMEOUT: wait counter reaches TIMEOUT_CYCLES.
  - 6 READ_STRB: PSEL & !PWRITE with PSTRB != 0.
- Address, control, PSTRB and PWDATA are captured on entry to SETUP and on every wait cycle, and compared on the next cycle.
- Wait counter:
  - Increments each WAIT-qualifying cycle and clears on completion or on leaving ACCESS.
  - Saturates at TIMEOUT_CYCLES.
  - Bit 5 fires once per transfer, on the cycle the count reaches TIMEOUT_CYCLES.
- Counters:
  - wr_count/rd_count increment on completion, including PSLVERR responses.
  - err_count increments by 1 per cycle in which any flag condition is true.
  - All counters saturate at all-ones.
- First-error capture:
  - Loads on the first violating cycle while first_valid is low.
  - Simultaneous violations resolve to the lowest bit index.
- clr: zeroes flags, counters and capture next edge. If a violation occurs on the same cycle as clr, the new violation is recorded after the clear (violation wins; counts restart at 1).
- After reset deassertion, checks 0 and 2 are suppressed on the first sampled edge, so that a transfer in flight is not falsely flagged.

## Timing
- PRESET high: all outputs 0, FSM IDLE, wait counter 0, capture empty; takes effect immediately.
- Violation sampled at edge N: err_flags, err_count and capture update at edge N. They are visible after that edge (1-cycle latency), and irq follows one edge later (N+1).
- Completion at edge N: wr_count or rd_count updates at edge N.
- Back-to-back transfer (completion followed directly by SETUP) is legal; no flag.
- Reset mid-transfer: all state discarded; no flags on resumption per suppression rule.

## Test plan
- Write to 0x10, 0 wait states, then read 0x10 with PSTRB=0 -> wr_count=1, rd_count=1, err_flags=0, irq=0.
- Write with 3 wait states, PWDATA changed 0xA5->0x5A during the 2nd wait cycle -> err_flags[2]=1, first_err_code=2, first_err_addr=write address, irq high 2 edges after the change.
- TIMEOUT_CYCLES=4, PREADY held low for 6 cycles then high -> err_flags[5]=1, err_count=1 (single fire), wr_count=1 on completion.
- PENABLE asserted with PSEL in IDLE, plus PSLVERR high in the same cycle -> err_flags[0] and err_flags[3] set, err_count=1, first_err_code=0.
- Read at PADDR=MEM_DEPTH completing with PSLVERR=0 -> err_flags[4]=1. Repeat with PSLVERR=1 -> no new flag, rd_count=2.
- clr pulsed together with a READ_STRB violation (PSTRB=4'hF on a read) -> after the edge, err_flags=7'h40, err_count=1, first_err_code=6. Assert PRESET mid-wait -> all outputs 0 immediately.
